// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: the head word is read combinationally
// from storage, and the flags come from registered wrap-bit pointers only.
module sync_fifo_fwft #(
    parameter int unsigned DLEN  = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_wen,
    input  logic [DLEN-1:0] i_wdata,
    output logic            o_full,
    input  logic            i_ren,
    output logic [DLEN-1:0] o_rdata,
    output logic            o_empty,
    output logic [AW:0]     o_count,
    output logic            o_overflow,
    output logic            o_underflow
);

    logic [AW:0]     wptr_q, wptr_d;
    logic [AW:0]     rptr_q, rptr_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic            rd_ok, wr_ok;
    logic [DLEN-1:0] mem [DEPTH];

    assign o_empty     = (wptr_q == rptr_q);
    assign o_full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign o_count     = wptr_q - rptr_q;
    assign o_rdata     = mem[rptr_q[AW-1:0]];
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

    // A write at full is still taken when the same cycle pops the head.
    assign rd_ok = i_ren & ~o_empty;
    assign wr_ok = i_wen & (~o_full | i_ren);

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (i_wen && !wr_ok) begin
            overflow_d = 1'b1;
        end
        if (i_ren && o_empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr_q[AW-1:0]] <= i_wdata;
        end
    end

endmodule
